ps2_host_tx: RTL and testbench

Host-to-device PS/2 transmitter: serialises one command byte (LED update 0xED, reset 0xFF, typematic, mouse enable 0xF4, …) from the core to the keyboard or mouse over the open-drain clkps2/dataps2 or mouseclk/mousedata pair. It is the opposite direction of the existing PS/2 scancode receiver. It sits beside that receiver and shares the same bidirectional pins through output-enable lines. `busy` gates the receiver while a host frame is in flight.

---
 rtl/ps2_pkg.sv | 13 +
 rtl/ps2_sync_edge.sv | 24 ++
 rtl/ps2_host_tx.sv | 123 ++++++++++++
 tb/tb_ps2_host_tx.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 state encoding, frame constants and command bytes for host TX and scancode RX.
package ps2_pkg;
    typedef enum logic [2:0] {S_IDLE, S_INHIBIT, S_RTS, S_SHIFT, S_WAITIDLE, S_DONE, S_FAIL} ps2_state_t;
    localparam logic [3:0] LAST_BIT = 4'd11;
    localparam logic START = 1'b0;
    localparam logic STOP = 1'b1;
    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_ENABLE = 8'hF4;
    localparam logic [7:0] CMD_RESET = 8'hFF;
    function automatic logic odd_par(input logic [7:0] d);
        return ~^d;
    endfunction
endpackage

// File: rtl/ps2_sync_edge.sv
// ps2_sync_edge: 2-FF synchroniser for an asynchronous PS/2 pin plus falling-edge detector.
module ps2_sync_edge (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_pin,
    output logic o_level,
    output logic o_fall
);
    logic r_s1, r_s2, r_prev;
    // Idle PS/2 lines are high, so reset to 1 to avoid a spurious edge.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_s1   <= 1'b1;
            r_s2   <= 1'b1;
            r_prev <= 1'b1;
        end else begin
            r_s1   <= i_pin;
            r_s2   <= r_s1;
            r_prev <= r_s2;
        end
    end
    assign o_level = r_s2;
    assign o_fall  = r_prev & ~r_s2;
endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 frame transmitter driving open-drain clock/data via output enables.
// Define PS2_TX_TIMEOUT_EN to add a watchdog that aborts a frame when the device never finishes it.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int CLKFREQ    = 28_000_000,
    parameter int INHIBIT_US = 120,
    parameter int TIMEOUT_MS = 20
) (
    input  logic       sysclk,
    input  logic       rst_n,
    input  logic       ps2clk_in,
    input  logic       ps2data_in,
    output logic       ps2clk_oe,
    output logic       ps2data_oe,
    input  logic [7:0] tx_data,
    input  logic       send,
    output logic       busy,
    output logic       done,
    output logic       error
);
    localparam longint INHIBIT_CYC = longint'(CLKFREQ) * INHIBIT_US / 1000000;
    localparam int INW = $clog2(INHIBIT_CYC);
    localparam logic [INW-1:0] INH_LAST = INW'(INHIBIT_CYC - 1);

    ps2_state_t r_state, w_next;
    logic [INW-1:0] r_inh;
    logic [3:0] r_bitcnt;
    logic [8:0] r_frame;
    logic r_data_oe;
    logic w_clk_lvl, w_clk_fall, w_data_lvl, w_tmo;

    ps2_sync_edge u_clk_sync (
        .i_clk(sysclk), .i_rst_n(rst_n), .i_pin(ps2clk_in), .o_level(w_clk_lvl), .o_fall(w_clk_fall)
    );
    ps2_sync_edge u_data_sync (
        .i_clk(sysclk), .i_rst_n(rst_n), .i_pin(ps2data_in), .o_level(w_data_lvl), .o_fall()
    );

`ifdef PS2_TX_TIMEOUT_EN
    localparam longint TIMEOUT_CYC = longint'(CLKFREQ) / 1000 * TIMEOUT_MS;
    localparam int TW = $clog2(TIMEOUT_CYC);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
    logic [TW-1:0] r_tmo;
    // The RTS cycle counts as the first watchdog cycle.
    always_ff @(posedge sysclk) begin
        if (!rst_n || r_state == S_IDLE) r_tmo <= '0;
        else if (r_state == S_RTS) r_tmo <= TW'(1);
        else r_tmo <= r_tmo + 1'b1;
    end
    assign w_tmo = (r_state == S_SHIFT || r_state == S_WAITIDLE) && r_tmo == TMO_LAST;
`else
    assign w_tmo = 1'b0;
`endif

    always_ff @(posedge sysclk) begin
        if (!rst_n) r_state <= S_IDLE;
        else r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        ps2clk_oe  = 1'b0;
        ps2data_oe = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        error      = 1'b0;
        case (r_state)
            S_IDLE:     w_next = send ? S_INHIBIT : S_IDLE;
            S_INHIBIT: begin
                ps2clk_oe = 1'b1;
                busy      = 1'b1;
                w_next    = (r_inh == INH_LAST) ? S_RTS : S_INHIBIT;
            end
            S_RTS: begin
                ps2data_oe = 1'b1;
                busy       = 1'b1;
                w_next     = S_SHIFT;
            end
            S_SHIFT: begin
                ps2data_oe = r_data_oe;
                busy       = 1'b1;
                w_next     = w_tmo ? S_FAIL :
                             (w_clk_fall && r_bitcnt == LAST_BIT - 4'd1) ? (w_data_lvl ? S_FAIL : S_WAITIDLE) :
                             S_SHIFT;
            end
            S_WAITIDLE: begin
                busy   = 1'b1;
                w_next = w_tmo ? S_FAIL : (w_clk_lvl && w_data_lvl) ? S_DONE : S_WAITIDLE;
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            S_FAIL: begin
                error  = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Frame shifts out LSB first; STOP fills behind so edges 10 and 11 release data.
    always_ff @(posedge sysclk) begin
        if (!rst_n) begin
            r_inh     <= '0;
            r_bitcnt  <= '0;
            r_frame   <= '0;
            r_data_oe <= 1'b0;
        end else begin
            r_inh <= (r_state == S_INHIBIT) ? r_inh + 1'b1 : '0;
            if (r_state == S_IDLE && send) r_frame <= {odd_par(tx_data), tx_data};
            if (r_state == S_RTS) begin
                r_bitcnt  <= '0;
                r_data_oe <= ~START;
            end else if (r_state == S_SHIFT && w_clk_fall) begin
                r_bitcnt  <= r_bitcnt + 1'b1;
                r_data_oe <= ~r_frame[0];
                r_frame   <= {STOP, r_frame[8:1]};
            end
        end
    end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed bench with an open-drain PS/2 device model for ps2_host_tx.
module tb_ps2_host_tx;
    localparam int INH_CYC = 120;
    localparam int TMO_CYC = 2000;
    localparam int HALF = 20;

    typedef struct {
        logic [7:0]  data;
        logic        ack;
        logic        mid_send;
        logic [10:0] bits;
        logic        exp_done;
        logic        exp_err;
    } vec_t;

    logic sysclk = 1'b0;
    logic rst_n = 1'b0;
    logic send = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic ps2clk_oe, ps2data_oe, busy, done, error;
    logic dev_clk_low = 1'b0;
    logic dev_data_low = 1'b0;
    logic clk_pin, data_pin;
    int total = 0;
    int bad = 0;
    int n_done = 0;
    int n_err = 0;
    int inh_cnt = 0;
    vec_t vecs[7];

    assign clk_pin  = ~(ps2clk_oe | dev_clk_low);
    assign data_pin = ~(ps2data_oe | dev_data_low);

    always #5 sysclk = ~sysclk;

    ps2_host_tx #(.CLKFREQ(1_000_000), .INHIBIT_US(120), .TIMEOUT_MS(2)) dut (
        .sysclk(sysclk), .rst_n(rst_n), .ps2clk_in(clk_pin), .ps2data_in(data_pin),
        .ps2clk_oe(ps2clk_oe), .ps2data_oe(ps2data_oe), .tx_data(tx_data), .send(send),
        .busy(busy), .done(done), .error(error)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge sysclk) begin
        if (ps2clk_oe) inh_cnt++;
        if (done) n_done++;
        if (error) n_err++;
        if (done || error) check("busy_low_at_pulse", {31'd0, busy}, 32'd0);
    end

    task automatic wait_rts(output logic ok);
        ok = 1'b0;
        for (int t = 0; t < 1000 && !ok; t++) begin
            @(negedge sysclk);
            ok = clk_pin && !data_pin;
        end
        check("rts_seen", {31'd0, ok}, 32'd1);
    endtask

    task automatic device(input int n_edges, input logic ack, output logic [10:0] bits);
        logic ok;
        bits = '0;
        wait_rts(ok);
        if (!ok) return;
        for (int i = 0; i < n_edges; i++) begin
            repeat (HALF) @(negedge sysclk);
            bits[i] = data_pin;
            if (i == 10 && ack) begin
                dev_data_low = 1'b1;
                repeat (2) @(negedge sysclk);
            end
            dev_clk_low = 1'b1;
            repeat (HALF) @(negedge sysclk);
            dev_clk_low = 1'b0;
        end
        repeat (2) @(negedge sysclk);
        dev_data_low = 1'b0;
    endtask

    task automatic start(input logic [7:0] d);
        @(negedge sysclk);
        tx_data = d;
        send = 1'b1;
        @(negedge sysclk);
        send = 1'b0;
    endtask

    task automatic run(input vec_t v, input string tag);
        logic [10:0] bits;
        int d0, e0;
        d0 = n_done;
        e0 = n_err;
        inh_cnt = 0;
        start(v.data);
        check($sformatf("%s_clk_oe_accept", tag), {31'd0, ps2clk_oe}, 32'd1);
        check($sformatf("%s_busy_accept", tag), {31'd0, busy}, 32'd1);
        if (v.mid_send) begin
            repeat (5) @(negedge sysclk);
            start(8'hF4);
        end
        device(11, v.ack, bits);
        check($sformatf("%s_inhibit_len", tag), inh_cnt, INH_CYC);
        check($sformatf("%s_line_bits", tag), {21'd0, bits}, {21'd0, v.bits});
        for (int t = 0; t < 200 && busy; t++) @(negedge sysclk);
        check($sformatf("%s_busy_end", tag), {31'd0, busy}, 32'd0);
        repeat (10) @(negedge sysclk);
        check($sformatf("%s_done_cnt", tag), n_done - d0, {31'd0, v.exp_done});
        check($sformatf("%s_err_cnt", tag), n_err - e0, {31'd0, v.exp_err});
        check($sformatf("%s_oes_after", tag), {30'd0, ps2clk_oe, ps2data_oe}, 32'd0);
        check($sformatf("%s_busy_after", tag), {31'd0, busy}, 32'd0);
    endtask

    initial begin
        logic [10:0] bits;
        logic ok;
        int d0, e0, k, low;
        vecs[0] = '{8'hED, 1'b1, 1'b0, 11'b11_11101101_0, 1'b1, 1'b0};
        vecs[1] = '{8'h07, 1'b1, 1'b0, 11'b10_00000111_0, 1'b1, 1'b0};
        vecs[2] = '{8'h00, 1'b1, 1'b0, 11'b11_00000000_0, 1'b1, 1'b0};
        vecs[3] = '{8'hFF, 1'b1, 1'b1, 11'b11_11111111_0, 1'b1, 1'b0};
        vecs[4] = '{8'hA5, 1'b0, 1'b0, 11'b11_10100101_0, 1'b0, 1'b1};
        vecs[5] = '{8'h3C, 1'b1, 1'b0, 11'b11_00111100_0, 1'b1, 1'b0};
        vecs[6] = '{8'hFF, 1'b1, 1'b0, 11'b11_11111111_0, 1'b1, 1'b0};
        repeat (3) @(negedge sysclk);
        check("rst_clk_oe", {31'd0, ps2clk_oe}, 32'd0);
        check("rst_data_oe", {31'd0, ps2data_oe}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_error", {31'd0, error}, 32'd0);
        rst_n = 1'b1;
        @(negedge sysclk);
        for (int i = 0; i < 6; i++) run(vecs[i], $sformatf("v%0d", i));

        d0 = n_done;
        e0 = n_err;
        start(8'h00);
        device(5, 1'b1, bits);
        check("mid_data_oe_before_rst", {31'd0, ps2data_oe}, 32'd1);
        check("mid_busy_before_rst", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        @(negedge sysclk);
        check("mid_rst_oes", {30'd0, ps2clk_oe, ps2data_oe}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        repeat (3) @(negedge sysclk);
        rst_n = 1'b1;
        repeat (5) @(negedge sysclk);
        check("mid_rst_no_done", n_done - d0, 32'd0);
        check("mid_rst_no_error", n_err - e0, 32'd0);
        run(vecs[6], "post_rst");

        d0 = n_done;
        start(8'h3C);
        wait_rts(ok);
`ifdef PS2_TX_TIMEOUT_EN
        k = 0;
        while (k < TMO_CYC + 100 && !error) begin
            @(negedge sysclk);
            k++;
        end
        check("tmo_latency", k, TMO_CYC);
        check("tmo_oes", {30'd0, ps2clk_oe, ps2data_oe}, 32'd0);
        repeat (5) @(negedge sysclk);
        check("tmo_no_done", n_done - d0, 32'd0);
        check("tmo_busy_after", {31'd0, busy}, 32'd0);
`else
        low = 0;
        repeat (3000) begin
            @(negedge sysclk);
            if (!busy) low++;
        end
        check("no_dev_busy_drops", low, 32'd0);
        check("no_dev_no_done", n_done - d0, 32'd0);
        rst_n = 1'b0;
        repeat (2) @(negedge sysclk);
        rst_n = 1'b1;
        @(negedge sysclk);
        check("no_dev_rst_busy", {31'd0, busy}, 32'd0);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
